wb_sram_pipe: RTL and testbench
===============================

Name: wb_sram_pipe

Overview:
- Parametrised successor to the single-cycle Wishbone SRAM slave on the user-project bus.
- Configurable data width, depth, base address and read latency.
- Supports Wishbone B4 pipelined or classic handshake, byte-lane writes, out-of-range error responses, and optional zero-fill of the array after reset.
- Sits on the user Wishbone bus behind the address decoder. The memory array is behavioural, one word per entry.

Parameters:
- DW, 32, data width in bits; 32 or 64.
- WORDS, 256, array depth in words; power of two, at least 4.
- BASE_ADDR, 32'h3000_0000, byte address of word 0; aligned to WORDS*DW/8.
- RD_LAT, 1, cycles from acceptance to ack for every transfer; 1..4.
- PIPELINED, 1, 1 = B4 pipelined handshake, 0 = classic handshake.
- CLEAR_ON_RESET, 0, 1 = zero-fill the array after reset release.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_ni  in  1  asynchronous active-low reset.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  DW  write data.
- wb_sel_i  in  DW/8  byte-lane enables.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination (out-of-range address).
- wb_stall_o  out  1  slave cannot accept this cycle.
- wb_dat_o  out  DW  read data; valid only while wb_ack_o is 1.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (wb_rst_ni).
- Reset values:
  - wb_ack_o = 0, wb_err_o = 0, wb_dat_o = 0.
  - Response pipeline is emptied.
  - wb_stall_o = 1 if CLEAR_ON_RESET, else 0.
- Address decode:
  - Word index = (wb_adr_i - BASE_ADDR) >> log2(DW/8). Low address bits are ignored.
  - A transfer is in range iff BASE_ADDR <= wb_adr_i < BASE_ADDR + WORDS*DW/8.
- State machine (INIT, RUN):
  - INIT is entered at reset release only when CLEAR_ON_RESET = 1.
  - In INIT a counter writes zero to words 0..WORDS-1, one word per cycle, with wb_stall_o = 1 and no transfer accepted.
  - After WORDS cycles the block moves to RUN.
  - When CLEAR_ON_RESET = 0 the block starts in RUN.
  - Asserting reset during INIT restarts the fill from word 0 after release.
- Acceptance:
  - PIPELINED = 1: a transfer is accepted in any RUN cycle with cyc & stb & !wb_stall_o. wb_stall_o is 0 in RUN, so back-to-back transfers run at one per cycle.
  - PIPELINED = 0: a transfer is accepted when cyc & stb and no transfer is in flight and wb_ack_o/wb_err_o is 0. The master holds stb until termination. wb_stall_o mirrors the internal busy state.
- Write commit:
  - An accepted in-range write updates the array in the acceptance cycle, only on lanes with wb_sel_i = 1.
  - An out-of-range write changes nothing.
- Read sampling: an accepted read samples the array at acceptance, so it sees any write accepted in an earlier cycle (no hazard).
- Response pipeline:
  - RD_LAT-deep shift register of {valid, err, data}.
  - Each accepted transfer produces exactly one response, exactly RD_LAT cycles later, in order.
  - wb_ack_o = valid & !err; wb_err_o = valid & err; never both.
  - wb_dat_o = read data on read acks, 0 on write acks, errors and idle cycles.
- Abort: wb_cyc_i low clears all in-flight valid bits that same cycle, so no ack/err is issued for aborted transfers. Writes already committed stay committed.
- Reset mid-transfer: pending responses are dropped. Array contents are preserved unless CLEAR_ON_RESET = 1.
- Depth wrap: there is none; any address outside the window gives an error, never an alias.

Test Plan:
- Pipelined RD_LAT=1 (DW=32, WORDS=256, BASE_ADDR=0x3000_0000, PIPELINED=1, CLEAR_ON_RESET=0):
  - Stimulus: write 0xDEADBEEF at 0x3000_0010 with sel=4'hF, then reads of 0x3000_0010 and 0x3000_0014 on consecutive cycles.
  - Required: three acks on consecutive cycles, one cycle after each accept; first read returns 0xDEADBEEF; stall stays 0.
- Byte lanes:
  - Stimulus: write 0x11223344, then write 0xAABBCCDD with sel=4'b0101 to the same word, then read it back.
  - Required: read returns 0x11BB33DD.
- Classic mode (PIPELINED=0, RD_LAT=3):
  - Stimulus: hold stb on a read.
  - Required: ack exactly 3 cycles after accept, for one cycle; the second strobe is not accepted before that ack.
- Out of range:
  - Stimulus: read 0x3000_0400 (WORDS=256), then write 0x3000_0400.
  - Required: wb_err_o pulses for each, wb_ack_o stays 0, wb_dat_o = 0, array unchanged.
- Abort (RD_LAT=3):
  - Stimulus: issue 3 pipelined reads, drop cyc on the cycle after the third accept.
  - Required: no ack/err appears afterwards; the next cycle's read acks normally.
- Clear on reset (CLEAR_ON_RESET=1, WORDS=16):
  - Stimulus: release reset, pulse wb_rst_ni low after 5 cycles, release again.
  - Required: stall stays 1 for 16 cycles after the final release; all reads of words 0..15 then return 0.

Source files
------------

// File: rtl/wb_sram_pipe.sv
// wb_sram_pipe: Wishbone slave in front of a behavioural single-port word array.
//
// Purpose
//   Parametrised SRAM slave for the user Wishbone bus. It decodes a fixed
//   address window, performs byte-lane writes, and returns every response
//   exactly RD_LAT cycles after acceptance through a shift register. Addresses
//   outside the window terminate with wb_err_o. An optional INIT phase
//   zero-fills the array after reset release.
//
// Ports
//   wb_clk_i    in   clock
//   wb_rst_ni   in   asynchronous active-low reset
//   wb_adr_i    in   byte address (32 bits)
//   wb_dat_i    in   write data (DW bits)
//   wb_sel_i    in   byte-lane enables (DW/8 bits)
//   wb_we_i     in   write enable
//   wb_cyc_i    in   bus cycle; low aborts all outstanding responses
//   wb_stb_i    in   strobe
//   wb_ack_o    out  normal termination
//   wb_err_o    out  error termination (address outside the window)
//   wb_stall_o  out  slave cannot accept a transfer this cycle
//   wb_dat_o    out  read data, non-zero only on read acks
//
// Handshake
//   A request is offered while wb_cyc_i & wb_stb_i are high and is taken on a
//   clock edge where wb_stall_o is low (the "ready" side). Pipelined mode keeps
//   wb_stall_o low in RUN, so one transfer per cycle is taken. Classic mode
//   raises wb_stall_o while any response is outstanding, so the master's held
//   strobe is taken again only after the previous termination has retired.
//   Each taken transfer yields exactly one ack or err RD_LAT cycles later,
//   unless wb_cyc_i drops first.

module wb_sram_pipe #(
  parameter int unsigned DW             = 32,
  parameter int unsigned WORDS          = 256,
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned PIPELINED      = 1,
  parameter int unsigned CLEAR_ON_RESET = 0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic [31:0]     wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_stall_o,
  output logic [DW-1:0]   wb_dat_o
);

  localparam int unsigned SW  = DW / 8;
  localparam int unsigned OFF = $clog2(SW);
  localparam int unsigned AW  = $clog2(WORDS);
  // Window size in bytes, one bit wider so BASE_ADDR + size cannot overflow.
  localparam logic [32:0] WIN_BYTES = 33'(WORDS * SW);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   fill_idx;
  logic [AW-1:0]   fill_nxt;
  logic            fill_we;

  logic [31:0]     offset;
  logic            in_range;
  logic [AW-1:0]   word_idx;
  logic            run;
  logic            busy;
  logic            accept;
  logic [DW-1:0]   rd_data;

  logic [DW-1:0]   mem [WORDS];

  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_err;
  logic [DW-1:0]     pipe_dat [RD_LAT];
  logic              out_vld;

  // ---------------------------------------------------------------------------
  // INIT / RUN state machine. INIT walks fill_idx over every word once.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      fill_idx <= '0;
    end else begin
      state    <= state_nxt;
      fill_idx <= fill_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_idx;
    fill_we   = 1'b0;
    case (state)
      ST_INIT: begin
        fill_we = 1'b1;
        if (fill_idx == AW'(WORDS - 1)) begin
          state_nxt = ST_RUN;
        end else begin
          fill_nxt = fill_idx + AW'(1);
        end
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  assign run = (state == ST_RUN);

  // ---------------------------------------------------------------------------
  // Address decode. The subtraction wraps for addresses below the base, so a
  // single unsigned compare covers both window edges and nothing aliases.
  // ---------------------------------------------------------------------------
  assign offset   = wb_adr_i - BASE_ADDR;
  assign in_range = ({1'b0, offset} < WIN_BYTES);
  assign word_idx = offset[OFF +: AW];

  // ---------------------------------------------------------------------------
  // Acceptance. In classic mode any outstanding response keeps the slave busy,
  // which also covers the cycle in which ack/err is being presented.
  // ---------------------------------------------------------------------------
  assign busy       = |pipe_vld;
  assign wb_stall_o = !run || ((PIPELINED == 0) && busy);
  assign accept     = wb_cyc_i && wb_stb_i && !wb_stall_o;

  // ---------------------------------------------------------------------------
  // Array. No reset on the storage itself so contents survive a bus reset;
  // writes are gated by wb_rst_ni so nothing commits while reset is held.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_ni) begin
      if (fill_we) begin
        mem[fill_idx] <= '0;
      end else if (accept && wb_we_i && in_range) begin
        for (int b = 0; b < int'(SW); b++) begin
          if (wb_sel_i[b]) begin
            mem[word_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
          end
        end
      end
    end
  end

  // Reads sample the array in the acceptance cycle; writes and errors carry 0.
  assign rd_data = (accept && !wb_we_i && in_range) ? mem[word_idx] : '0;

  // ---------------------------------------------------------------------------
  // Response shift register, RD_LAT stages of {valid, err, data}.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      pipe_vld <= '0;
      pipe_err <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
        pipe_dat[i] <= '0;
      end
    end else begin
      for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_err[i] <= pipe_err[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
      pipe_vld[0] <= accept;
      pipe_err[0] <= accept && !in_range;
      pipe_dat[0] <= rd_data;
      // Abort: dropping cyc discards every outstanding response.
      if (!wb_cyc_i) begin
        pipe_vld <= '0;
      end
    end
  end

  // The output stage is also qualified by cyc so a response due in the very
  // cycle the master aborts is suppressed as well.
  assign out_vld  = pipe_vld[RD_LAT-1] && wb_cyc_i;
  assign wb_ack_o = out_vld && !pipe_err[RD_LAT-1];
  assign wb_err_o = out_vld && pipe_err[RD_LAT-1];
  assign wb_dat_o = wb_ack_o ? pipe_dat[RD_LAT-1] : '0;

endmodule

// File: tb/tb_wb_sram_pipe.sv
// Directed bench for wb_sram_pipe. Three instances share the request bus but
// each has its own cyc and reset, so only one responds at a time:
//   u_a  pipelined, RD_LAT=1, WORDS=256
//   u_b  classic,   RD_LAT=3, WORDS=256
//   u_c  pipelined, RD_LAT=3, WORDS=16, zero-fill after reset
// Inputs change on the falling edge; outputs are sampled on the falling edge
// before the inputs are changed.

module tb_wb_sram_pipe;

  logic        clk;
  logic        rst_a, rst_b, rst_c;
  logic        cyc_a, cyc_b, cyc_c;
  logic        stb, we;
  logic [31:0] adr, dat_w;
  logic [3:0]  sel;

  logic        ack_a, err_a, stall_a;
  logic        ack_b, err_b, stall_b;
  logic        ack_c, err_c, stall_c;
  logic [31:0] dat_a, dat_b, dat_c;

  int checks = 0;
  int errors = 0;

  wb_sram_pipe #(
    .DW(32), .WORDS(256), .BASE_ADDR(32'h3000_0000), .RD_LAT(1),
    .PIPELINED(1), .CLEAR_ON_RESET(0)
  ) u_a (
    .wb_clk_i(clk), .wb_rst_ni(rst_a), .wb_adr_i(adr), .wb_dat_i(dat_w),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc_a), .wb_stb_i(stb),
    .wb_ack_o(ack_a), .wb_err_o(err_a), .wb_stall_o(stall_a), .wb_dat_o(dat_a)
  );

  wb_sram_pipe #(
    .DW(32), .WORDS(256), .BASE_ADDR(32'h3000_0000), .RD_LAT(3),
    .PIPELINED(0), .CLEAR_ON_RESET(0)
  ) u_b (
    .wb_clk_i(clk), .wb_rst_ni(rst_b), .wb_adr_i(adr), .wb_dat_i(dat_w),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc_b), .wb_stb_i(stb),
    .wb_ack_o(ack_b), .wb_err_o(err_b), .wb_stall_o(stall_b), .wb_dat_o(dat_b)
  );

  wb_sram_pipe #(
    .DW(32), .WORDS(16), .BASE_ADDR(32'h3000_0000), .RD_LAT(3),
    .PIPELINED(1), .CLEAR_ON_RESET(1)
  ) u_c (
    .wb_clk_i(clk), .wb_rst_ni(rst_c), .wb_adr_i(adr), .wb_dat_i(dat_w),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc_c), .wb_stb_i(stb),
    .wb_ack_o(ack_c), .wb_err_o(err_c), .wb_stall_o(stall_c), .wb_dat_o(dat_c)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Driver tasks and checker
  // ---------------------------------------------------------------------------
  task automatic drive(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    stb   = 1'b1;
    we    = w;
    adr   = a;
    dat_w = d;
    sel   = s;
  endtask

  task automatic idle();
    stb   = 1'b0;
    we    = 1'b0;
    adr   = 32'h0;
    dat_w = 32'h0;
    sel   = 4'h0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    cyc_a = 1'b0; cyc_b = 1'b0; cyc_c = 1'b0;
    idle();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_a_ack",   ack_a,   1'b0);
    check("rst_a_err",   err_a,   1'b0);
    check("rst_a_dat",   dat_a,   32'h0);
    check("rst_a_stall", stall_a, 1'b0);
    check("rst_b_stall", stall_b, 1'b0);
    check("rst_c_stall", stall_c, 1'b1);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // ---- A: pipelined RD_LAT=1 -------------------------------------------
    @(negedge clk); cyc_a = 1'b1; drive(1'b1, 32'h3000_0014, 32'h0BAD_F00D, 4'hF);
    @(negedge clk); check("a_pre0_ack", ack_a, 1'b1);
    drive(1'b1, 32'h3000_0000, 32'h1234_5678, 4'hF);
    @(negedge clk); check("a_pre1_ack", ack_a, 1'b1);
    drive(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    check("a_wr_ack",   ack_a,   1'b1);
    check("a_wr_dat",   dat_a,   32'h0);
    check("a_wr_stall", stall_a, 1'b0);
    drive(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    @(negedge clk);
    check("a_rd0_ack",   ack_a,   1'b1);
    check("a_rd0_dat",   dat_a,   32'hDEAD_BEEF);
    check("a_rd0_stall", stall_a, 1'b0);
    drive(1'b0, 32'h3000_0014, 32'h0, 4'hF);
    @(negedge clk);
    check("a_rd1_ack", ack_a, 1'b1);
    check("a_rd1_dat", dat_a, 32'h0BAD_F00D);
    idle();
    @(negedge clk);
    check("a_idle_ack", ack_a, 1'b0);
    check("a_idle_dat", dat_a, 32'h0);

    // Byte lanes
    drive(1'b1, 32'h3000_0020, 32'h1122_3344, 4'hF);
    @(negedge clk); check("a_bl_wr0_ack", ack_a, 1'b1);
    drive(1'b1, 32'h3000_0020, 32'hAABB_CCDD, 4'b0101);
    @(negedge clk); check("a_bl_wr1_ack", ack_a, 1'b1);
    drive(1'b0, 32'h3000_0020, 32'h0, 4'hF);
    @(negedge clk);
    check("a_bl_rd_ack", ack_a, 1'b1);
    check("a_bl_rd_dat", dat_a, 32'h11BB_33DD);

    // Out of range, then confirm word 0 (the would-be alias) is untouched
    drive(1'b0, 32'h3000_0400, 32'h0, 4'hF);
    @(negedge clk);
    check("a_oor_rd_err", err_a, 1'b1);
    check("a_oor_rd_ack", ack_a, 1'b0);
    check("a_oor_rd_dat", dat_a, 32'h0);
    drive(1'b1, 32'h3000_0400, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    check("a_oor_wr_err", err_a, 1'b1);
    check("a_oor_wr_ack", ack_a, 1'b0);
    check("a_oor_wr_dat", dat_a, 32'h0);
    drive(1'b0, 32'h2FFF_FFFC, 32'h0, 4'hF);
    @(negedge clk);
    check("a_below_err", err_a, 1'b1);
    check("a_below_ack", ack_a, 1'b0);
    drive(1'b0, 32'h3000_0000, 32'h0, 4'hF);
    @(negedge clk);
    check("a_w0_ack", ack_a, 1'b1);
    check("a_w0_err", err_a, 1'b0);
    check("a_w0_dat", dat_a, 32'h1234_5678);
    drive(1'b1, 32'h3000_03FC, 32'h5A5A_0001, 4'hF);
    @(negedge clk);
    check("a_last_wr_ack", ack_a, 1'b1);
    check("a_last_wr_err", err_a, 1'b0);
    drive(1'b0, 32'h3000_03FC, 32'h0, 4'hF);
    @(negedge clk);
    check("a_last_rd_dat", dat_a, 32'h5A5A_0001);
    idle();
    @(negedge clk);
    check("a_tail_ack", ack_a, 1'b0);
    check("a_tail_err", err_a, 1'b0);

    // Reset with a response showing: it is dropped, contents survive
    drive(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    @(negedge clk);
    rst_a = 1'b0;
    idle();
    #1;
    check("a_rstmid_ack", ack_a, 1'b0);
    check("a_rstmid_dat", dat_a, 32'h0);
    @(negedge clk); rst_a = 1'b1;
    drive(1'b0, 32'h3000_0010, 32'h0, 4'hF);
    @(negedge clk);
    check("a_keep_ack", ack_a, 1'b1);
    check("a_keep_dat", dat_a, 32'hDEAD_BEEF);
    idle(); cyc_a = 1'b0;

    // ---- B: classic RD_LAT=3 ---------------------------------------------
    @(negedge clk); cyc_b = 1'b1; drive(1'b1, 32'h3000_0008, 32'hCAFE_F00D, 4'hF);
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      check("b_wr_ack", ack_b, (t == 3) ? 1'b1 : 1'b0);
      check("b_wr_stall", stall_b, 1'b1);
    end
    check("b_wr_dat", dat_b, 32'h0);
    idle();
    @(negedge clk);
    check("b_wr_done_ack", ack_b, 1'b0);
    check("b_wr_done_stall", stall_b, 1'b0);
    // Strobe held across two transfers: second is taken only after first ack
    drive(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      check("b_rd_ack", ack_b, (t == 3 || t == 7) ? 1'b1 : 1'b0);
      check("b_rd_err", err_b, 1'b0);
      if (t == 3 || t == 7) check("b_rd_dat", dat_b, 32'hCAFE_F00D);
      if (t == 1 || t == 5) check("b_rd_stall_hi", stall_b, 1'b1);
      if (t == 4) check("b_rd_stall_lo", stall_b, 1'b0);
      if (t == 7) idle();
    end
    cyc_b = 1'b0;

    // ---- C: write data, then zero-fill with a reset pulse mid-fill -------
    @(negedge clk); cyc_c = 1'b1; drive(1'b1, 32'h3000_0000, 32'hA5A5_0000, 4'hF);
    @(negedge clk); drive(1'b1, 32'h3000_001C, 32'hA5A5_0007, 4'hF);
    @(negedge clk); drive(1'b1, 32'h3000_003C, 32'hA5A5_000F, 4'hF);
    @(negedge clk); drive(1'b0, 32'h3000_001C, 32'h0, 4'hF);
    @(negedge clk); idle();
    @(negedge clk);
    @(negedge clk);
    check("c_pre_rd_ack", ack_c, 1'b1);
    check("c_pre_rd_dat", dat_c, 32'hA5A5_0007);
    cyc_c = 1'b0;

    @(negedge clk); rst_c = 1'b0;
    @(negedge clk); rst_c = 1'b1;
    repeat (5) @(negedge clk);
    rst_c = 1'b0;
    @(negedge clk); rst_c = 1'b1;
    #1;
    check("c_fill_stall", stall_c, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      check("c_fill_stall", stall_c, 1'b1);
    end
    @(negedge clk);
    check("c_run_stall", stall_c, 1'b0);

    cyc_c = 1'b1;
    for (int i = 0; i <= 18; i++) begin
      if (i >= 3) begin
        check("c_zero_ack", ack_c, 1'b1);
        check("c_zero_dat", dat_c, 32'h0);
      end
      if (i < 16) drive(1'b0, 32'h3000_0000 + 32'(4 * i), 32'h0, 4'hF);
      else idle();
      @(negedge clk);
    end

    // Just past the 16-word window: error, no alias onto word 0
    drive(1'b0, 32'h3000_0040, 32'h0, 4'hF);
    @(negedge clk); idle();
    @(negedge clk); check("c_oor_early", err_c, 1'b0);
    @(negedge clk);
    check("c_oor_err", err_c, 1'b1);
    check("c_oor_ack", ack_c, 1'b0);
    check("c_oor_dat", dat_c, 32'h0);

    // ---- C: abort --------------------------------------------------------
    drive(1'b1, 32'h3000_0004, 32'h0000_1111, 4'hF);
    @(negedge clk); drive(1'b1, 32'h3000_0008, 32'h0000_2222, 4'hF);
    @(negedge clk); drive(1'b1, 32'h3000_000C, 32'h0000_3333, 4'hF);
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    drive(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    @(negedge clk); drive(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    @(negedge clk); drive(1'b0, 32'h3000_000C, 32'h0, 4'hF);
    @(negedge clk);
    cyc_c = 1'b0;
    idle();
    #1;
    check("c_abort_ack0", ack_c, 1'b0);
    check("c_abort_err0", err_c, 1'b0);
    @(negedge clk);
    check("c_abort_ack1", ack_c, 1'b0);
    check("c_abort_err1", err_c, 1'b0);
    cyc_c = 1'b1;
    drive(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    @(negedge clk); idle();
    check("c_abort_ack2", ack_c, 1'b0);
    check("c_abort_err2", err_c, 1'b0);
    @(negedge clk);
    check("c_abort_ack3", ack_c, 1'b0);
    check("c_abort_err3", err_c, 1'b0);
    @(negedge clk);
    check("c_post_ack", ack_c, 1'b1);
    check("c_post_dat", dat_c, 32'h0000_2222);
    @(negedge clk);
    check("c_post_tail", ack_c, 1'b0);
    cyc_c = 1'b0;

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
